jtag_tap_responder: RTL and testbench
=====================================

JTAG_TAP_RESPONDER -- requirements
Module: jtag_tap_responder

Interface
REQ-001 Parameter IDCODE, 32'h020F10DD, value loaded into the 32-bit IDCODE DR on Capture-DR; bit 0 SHALL be 1.
REQ-002 Parameter USER_WIDTH, 16, width of the user data register.
REQ-003 i_clk  input  1  sole system clock; all logic SHALL be clocked on its rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_tck  input  1  JTAG TCK from the blaster, asynchronous to i_clk.
REQ-006 i_tms  input  1  JTAG TMS, asynchronous.
REQ-007 i_tdi  input  1  JTAG TDI, asynchronous.
REQ-008 o_tdo  output  1  JTAG TDO back to the blaster.
REQ-009 o_tdo_oe  output  1  high while TDO is driven, i.e. in Shift-IR/Shift-DR.
REQ-010 i_user_capture  input  USER_WIDTH  value loaded into the user DR on Capture-DR.
REQ-011 o_user_dr  output  USER_WIDTH  last value latched by Update-DR with USER selected.
REQ-012 o_user_update  output  1  one-i_clk pulse when o_user_dr is written.

Function
REQ-013 i_tck, i_tms and i_tdi SHALL each pass through a 2-FF synchronizer; a 3rd TCK flop SHALL give rise/fall detect; pin-to-action latency = 3 i_clk.
REQ-014 Correct operation SHALL require TCK high and low phases each >= 3 i_clk periods; faster TCK is unsupported, no detection required.
REQ-015 The TAP controller SHALL implement all 16 IEEE 1149.1 states with standard TMS-driven transitions, advanced only on a detected TCK rise, using the synchronized TMS.
REQ-016 On a TCK rise in Capture-IR, the IR shift register SHALL load 4'b0001.
REQ-017 On a TCK rise in Capture-DR, the selected DR SHALL load: IDCODE -> IDCODE; BYPASS -> 1'b0; USER -> i_user_capture.
REQ-018 On a TCK rise in Shift-IR/Shift-DR, the selected shift register SHALL shift right, synchronized TDI entering the MSB.
REQ-019 On a TCK fall, o_tdo SHALL take the LSB of the active shift register and o_tdo_oe SHALL go high, if the state is Shift-IR/Shift-DR; otherwise o_tdo_oe SHALL go low and o_tdo SHALL hold.
REQ-020 On a TCK fall in Update-IR, IR SHALL take the IR shift register value.
REQ-021 On a TCK fall in Update-DR with IR=USER, o_user_dr SHALL latch the user shift register and o_user_update SHALL pulse for exactly one i_clk.
REQ-022 IR opcodes (4-bit): IDCODE=4'b0001, USER=4'b0010, BYPASS=4'b1111; any other opcode SHALL select BYPASS.
REQ-023 Entering Test-Logic-Reset, by five TMS=1 rises from any state or by reset, SHALL set IR=IDCODE; o_user_dr SHALL be unaffected.
REQ-024 Capture, shift and update SHALL act only on the DR selected by the current IR; unselected registers hold.

Reset
REQ-025 i_reset_n low SHALL immediately force: TAP state Test-Logic-Reset, IR=IDCODE, all shift registers 0, o_tdo=0, o_tdo_oe=0, o_user_dr=0, o_user_update=0, synchronizer flops 0.
REQ-026 Reset mid-shift SHALL abort the scan; after release, the first detected TCK rise is evaluated from Test-Logic-Reset.

Structure
REQ-027 Package jtag_tap_pkg SHALL hold tap_state_t (16-state enum), IR_WIDTH=4, opcode constants and the IR capture constant.
REQ-028 Next-state logic SHALL live in sub-module jtag_tap_fsm (inputs: state, tms; output: next state); the synchronizers, registers and TDO logic stay in jtag_tap_responder.

Verification
REQ-029 After reset: 5 TMS=1 TCKs, go to Shift-DR, shift 32 bits -> TDO returns 0x020F10DD LSB-first; o_tdo_oe=1 only during the shift.
REQ-030 Shift-IR out after reset -> TDO returns 4'b0001; shift in 4'b1111, Update-IR, then shift DR pattern 8'hA5 -> TDO shows a 0 followed by the bits of A5, one-bit delay.
REQ-031 IR=USER, i_user_capture=16'h1234, shift in 16'hBEEF, Update-DR -> TDO returns 16'h1234; o_user_dr=16'hBEEF; exactly one o_user_update pulse.
REQ-032 From Shift-IR, 5 TMS=1 TCKs -> Test-Logic-Reset, IR=IDCODE; the next DR scan returns IDCODE.
REQ-033 i_reset_n pulsed low mid Shift-DR -> o_tdo_oe=0 and IR=IDCODE before the next i_clk edge; the next scan behaves as in REQ-029.
REQ-034 IR=4'b0101 (undefined) -> DR scan behaves as BYPASS.

Source files
------------

// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the JTAG TAP responder: TAP state encoding,
// IR opcodes and the decode from IR to the selected data register.
package jtag_tap_pkg;

  localparam int IR_WIDTH = 4;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0001;
  localparam logic [IR_WIDTH-1:0] OP_IDCODE  = 4'b0001;
  localparam logic [IR_WIDTH-1:0] OP_USER    = 4'b0010;
  localparam logic [IR_WIDTH-1:0] OP_BYPASS  = 4'b1111;

  typedef enum logic [3:0] {
    ST_TLR     = 4'd0,
    ST_RTI     = 4'd1,
    ST_SEL_DR  = 4'd2,
    ST_CAP_DR  = 4'd3,
    ST_SH_DR   = 4'd4,
    ST_EX1_DR  = 4'd5,
    ST_PA_DR   = 4'd6,
    ST_EX2_DR  = 4'd7,
    ST_UPD_DR  = 4'd8,
    ST_SEL_IR  = 4'd9,
    ST_CAP_IR  = 4'd10,
    ST_SH_IR   = 4'd11,
    ST_EX1_IR  = 4'd12,
    ST_PA_IR   = 4'd13,
    ST_EX2_IR  = 4'd14,
    ST_UPD_IR  = 4'd15
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_t;

  // Unknown opcodes fall back to BYPASS so an undefined IR never corrupts a register.
  function automatic dr_sel_t decode_ir(input logic [IR_WIDTH-1:0] ir);
    dr_sel_t sel;
    case (ir)
      OP_IDCODE: sel = DR_IDCODE;
      OP_USER:   sel = DR_USER;
      default:   sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_tap_responder_if.sv
// JTAG pin bundle between a blaster (master) and the TAP responder (slave).
// tck/tms/tdi are driven by the master; tdo/tdo_oe are returned by the slave.
interface jtag_tap_responder_if;
  logic tck;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_oe;

  modport master (output tck, output tms, output tdi, input tdo, input tdo_oe);
  modport slave  (input tck, input tms, input tdi, output tdo, output tdo_oe);
endinterface

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller next-state function; purely combinational, the
// state register lives in the parent and only advances on a detected TCK rise.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  tap_state_t state,
  input  logic       tms,
  output tap_state_t next_state
);

  always_comb begin
    next_state = state;
    case (state)
      ST_TLR:    next_state = tms ? ST_TLR    : ST_RTI;
      ST_RTI:    next_state = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: next_state = tms ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: next_state = tms ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  next_state = tms ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: next_state = tms ? ST_UPD_DR : ST_PA_DR;
      ST_PA_DR:  next_state = tms ? ST_EX2_DR : ST_PA_DR;
      ST_EX2_DR: next_state = tms ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: next_state = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: next_state = tms ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: next_state = tms ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  next_state = tms ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: next_state = tms ? ST_UPD_IR : ST_PA_IR;
      ST_PA_IR:  next_state = tms ? ST_EX2_IR : ST_PA_IR;
      ST_EX2_IR: next_state = tms ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: next_state = tms ? ST_SEL_DR : ST_RTI;
      default:   next_state = ST_TLR;
    endcase
  end

endmodule

// File: rtl/jtag_tap_responder.sv
// JTAG TAP responder oversampling TCK/TMS/TDI in the i_clk domain; provides
// IDCODE, BYPASS and a USER data register. TAP state and IR exposed for debug.
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter logic [31:0] IDCODE     = 32'h020F10DD,
  parameter int          USER_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_tck,
  input  logic                  i_tms,
  input  logic                  i_tdi,
  output logic                  o_tdo,
  output logic                  o_tdo_oe,
  input  logic [USER_WIDTH-1:0] i_user_capture,
  output logic [USER_WIDTH-1:0] o_user_dr,
  output logic                  o_user_update,
  output tap_state_t            o_dbg_state,
  output logic [IR_WIDTH-1:0]   o_dbg_ir
);

  // tck_sync_q[1:0] is the 2-FF synchronizer; tck_sync_q[2] is the edge-detect history.
  logic [2:0]            tck_sync_q, tck_sync_d;
  logic [1:0]            tms_sync_q, tms_sync_d;
  logic [1:0]            tdi_sync_q, tdi_sync_d;
  tap_state_t            state_q, state_d, fsm_next;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic [IR_WIDTH-1:0]   ir_sr_q, ir_sr_d;
  logic [31:0]           idcode_sr_q, idcode_sr_d;
  logic                  bypass_sr_q, bypass_sr_d;
  logic [USER_WIDTH-1:0] user_sr_q, user_sr_d;
  logic [USER_WIDTH-1:0] user_dr_q, user_dr_d;
  logic                  user_update_q, user_update_d;
  logic                  tdo_q, tdo_d;
  logic                  tdo_oe_q, tdo_oe_d;

  logic    tck_rise, tck_fall, tms_s, tdi_s, dr_lsb;
  dr_sel_t dr_sel;

  assign tck_rise = tck_sync_q[1] & ~tck_sync_q[2];
  assign tck_fall = ~tck_sync_q[1] & tck_sync_q[2];
  assign tms_s    = tms_sync_q[1];
  assign tdi_s    = tdi_sync_q[1];
  assign dr_sel   = decode_ir(ir_q);

  jtag_tap_fsm u_fsm (
    .state      (state_q),
    .tms        (tms_s),
    .next_state (fsm_next)
  );

  always_comb begin
    case (dr_sel)
      DR_IDCODE: dr_lsb = idcode_sr_q[0];
      DR_USER:   dr_lsb = user_sr_q[0];
      default:   dr_lsb = bypass_sr_q;
    endcase
  end

  always_comb begin
    tck_sync_d    = {tck_sync_q[1:0], i_tck};
    tms_sync_d    = {tms_sync_q[0], i_tms};
    tdi_sync_d    = {tdi_sync_q[0], i_tdi};
    state_d       = state_q;
    ir_d          = ir_q;
    ir_sr_d       = ir_sr_q;
    idcode_sr_d   = idcode_sr_q;
    bypass_sr_d   = bypass_sr_q;
    user_sr_d     = user_sr_q;
    user_dr_d     = user_dr_q;
    user_update_d = 1'b0;
    tdo_d         = tdo_q;
    tdo_oe_d      = tdo_oe_q;

    if (tck_rise) begin
      state_d = fsm_next;
      case (state_q)
        ST_CAP_IR: ir_sr_d = IR_CAPTURE;
        ST_SH_IR:  ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
        ST_CAP_DR: begin
          case (dr_sel)
            DR_IDCODE: idcode_sr_d = IDCODE;
            DR_USER:   user_sr_d   = i_user_capture;
            default:   bypass_sr_d = 1'b0;
          endcase
        end
        ST_SH_DR: begin
          case (dr_sel)
            DR_IDCODE: idcode_sr_d = {tdi_s, idcode_sr_q[31:1]};
            DR_USER:   user_sr_d   = {tdi_s, user_sr_q[USER_WIDTH-1:1]};
            default:   bypass_sr_d = tdi_s;
          endcase
        end
        default: ;
      endcase
    end else if (tck_fall) begin
      tdo_oe_d = 1'b0;
      if (state_q == ST_SH_IR) begin
        tdo_d    = ir_sr_q[0];
        tdo_oe_d = 1'b1;
      end else if (state_q == ST_SH_DR) begin
        tdo_d    = dr_lsb;
        tdo_oe_d = 1'b1;
      end
      if (state_q == ST_UPD_IR) ir_d = ir_sr_q;
      if (state_q == ST_UPD_DR && dr_sel == DR_USER) begin
        user_dr_d     = user_sr_q;
        user_update_d = 1'b1;
      end
    end

    if (state_d == ST_TLR) ir_d = OP_IDCODE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tck_sync_q    <= '0;
      tms_sync_q    <= '0;
      tdi_sync_q    <= '0;
      state_q       <= ST_TLR;
      ir_q          <= OP_IDCODE;
      ir_sr_q       <= '0;
      idcode_sr_q   <= '0;
      bypass_sr_q   <= 1'b0;
      user_sr_q     <= '0;
      user_dr_q     <= '0;
      user_update_q <= 1'b0;
      tdo_q         <= 1'b0;
      tdo_oe_q      <= 1'b0;
    end else begin
      tck_sync_q    <= tck_sync_d;
      tms_sync_q    <= tms_sync_d;
      tdi_sync_q    <= tdi_sync_d;
      state_q       <= state_d;
      ir_q          <= ir_d;
      ir_sr_q       <= ir_sr_d;
      idcode_sr_q   <= idcode_sr_d;
      bypass_sr_q   <= bypass_sr_d;
      user_sr_q     <= user_sr_d;
      user_dr_q     <= user_dr_d;
      user_update_q <= user_update_d;
      tdo_q         <= tdo_d;
      tdo_oe_q      <= tdo_oe_d;
    end
  end

  assign o_tdo         = tdo_q;
  assign o_tdo_oe      = tdo_oe_q;
  assign o_user_dr     = user_dr_q;
  assign o_user_update = user_update_q;
  assign o_dbg_state   = state_q;
  assign o_dbg_ir      = ir_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: drives JTAG scans through the pin
// interface at a slow TCK and compares against hand-computed expected values.
module tb_jtag_tap_responder;
  import jtag_tap_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] user_cap;
  logic [15:0] user_dr;
  logic        user_upd;
  tap_state_t  dbg_state;
  logic [3:0]  dbg_ir;
  int          n_checks;
  int          n_fail;
  int          upd_cnt;

  jtag_tap_responder_if jif ();

  jtag_tap_responder #(.IDCODE(32'h020F10DD), .USER_WIDTH(16)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_tck          (jif.tck),
    .i_tms          (jif.tms),
    .i_tdi          (jif.tdi),
    .o_tdo          (jif.tdo),
    .o_tdo_oe       (jif.tdo_oe),
    .i_user_capture (user_cap),
    .o_user_dr      (user_dr),
    .o_user_update  (user_upd),
    .o_dbg_state    (dbg_state),
    .o_dbg_ir       (dbg_ir)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) upd_cnt <= 0;
    else if (user_upd) upd_cnt <= upd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One TCK period: TCK low phase then high phase, 4 i_clk each. TDO is
  // sampled just before the rising edge, as a blaster would.
  task automatic tck_pulse(input logic tms, input logic tdi, output logic tdo_s, output logic oe_s);
    jif.tms = tms;
    jif.tdi = tdi;
    repeat (4) @(negedge clk);
    tdo_s = jif.tdo;
    oe_s  = jif.tdo_oe;
    jif.tck = 1'b1;
    repeat (4) @(negedge clk);
    jif.tck = 1'b0;
  endtask

  task automatic tck_n(input logic tms, input int n);
    logic t, o;
    for (int i = 0; i < n; i++) tck_pulse(tms, 1'b0, t, o);
  endtask

  // From Run-Test/Idle: scan n bits of IR or DR, return to Run-Test/Idle.
  task automatic scan(input logic is_ir, input int n, input logic [31:0] din,
                      output logic [31:0] dout, output int oe_bad);
    logic t, o;
    dout   = '0;
    oe_bad = 0;
    tck_pulse(1'b1, 1'b0, t, o);
    if (o) oe_bad++;
    if (is_ir) begin
      tck_pulse(1'b1, 1'b0, t, o);
      if (o) oe_bad++;
    end
    tck_pulse(1'b0, 1'b0, t, o);
    if (o) oe_bad++;
    tck_pulse(1'b0, 1'b0, t, o);
    if (o) oe_bad++;
    for (int i = 0; i < n; i++) begin
      tck_pulse(i == n - 1, din[i], t, o);
      dout[i] = t;
      if (!o) oe_bad++;
    end
    tck_pulse(1'b1, 1'b0, t, o);
    if (o) oe_bad++;
    tck_pulse(1'b0, 1'b0, t, o);
    if (o) oe_bad++;
    repeat (4) @(negedge clk);
  endtask

  task automatic go_idle();
    tck_n(1'b1, 5);
    tck_n(1'b0, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] dout;
    int          oe_bad;
    logic        t, o;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    jif.tck  = 1'b0;
    jif.tms  = 1'b1;
    jif.tdi  = 1'b0;
    user_cap = 16'h0000;
    repeat (3) @(negedge clk);

    check("rst_state", 32'(dbg_state), 32'(ST_TLR));
    check("rst_ir", 32'(dbg_ir), 32'h1);
    check("rst_tdo", 32'(jif.tdo), 32'h0);
    check("rst_oe", 32'(jif.tdo_oe), 32'h0);
    check("rst_user_dr", 32'(user_dr), 32'h0);
    check("rst_user_upd", 32'(user_upd), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // IDCODE scan after reset
    go_idle();
    check("idle_state", 32'(dbg_state), 32'(ST_RTI));
    scan(1'b0, 32, 32'h0, dout, oe_bad);
    check("idcode_dr", dout, 32'h020F10DD);
    check("idcode_oe", 32'(oe_bad), 32'h0);

    // IR capture value, load BYPASS, bypass delay on A5
    scan(1'b1, 4, 32'hF, dout, oe_bad);
    check("ir_capture", dout & 32'hF, 32'h1);
    check("ir_oe", 32'(oe_bad), 32'h0);
    check("ir_bypass", 32'(dbg_ir), 32'hF);
    scan(1'b0, 8, 32'hA5, dout, oe_bad);
    check("bypass_a5", dout & 32'hFF, 32'h4A);

    // USER register: capture 1234, shift in BEEF
    user_cap = 16'h1234;
    scan(1'b1, 4, 32'h2, dout, oe_bad);
    check("ir_user", 32'(dbg_ir), 32'h2);
    scan(1'b0, 16, 32'hBEEF, dout, oe_bad);
    check("user_capture", dout & 32'hFFFF, 32'h1234);
    check("user_dr", 32'(user_dr), 32'hBEEF);
    check("user_upd_cnt", 32'(upd_cnt), 32'h1);

    // Undefined opcode behaves as BYPASS and leaves USER alone
    scan(1'b1, 4, 32'h5, dout, oe_bad);
    check("ir_undef", 32'(dbg_ir), 32'h5);
    scan(1'b0, 8, 32'h3C, dout, oe_bad);
    check("undef_bypass", dout & 32'hFF, 32'h78);
    check("undef_user_dr", 32'(user_dr), 32'hBEEF);
    check("undef_upd_cnt", 32'(upd_cnt), 32'h1);

    // Five TMS=1 from Shift-IR reaches Test-Logic-Reset
    tck_n(1'b1, 2);
    tck_n(1'b0, 2);
    repeat (4) @(negedge clk);
    check("in_shift_ir", 32'(dbg_state), 32'(ST_SH_IR));
    tck_n(1'b1, 5);
    repeat (4) @(negedge clk);
    check("tlr_state", 32'(dbg_state), 32'(ST_TLR));
    check("tlr_ir", 32'(dbg_ir), 32'h1);
    check("tlr_user_dr", 32'(user_dr), 32'hBEEF);
    tck_n(1'b0, 1);
    repeat (4) @(negedge clk);
    scan(1'b0, 32, 32'h0, dout, oe_bad);
    check("tlr_idcode", dout, 32'h020F10DD);

    // Asynchronous reset in the middle of a DR shift
    scan(1'b1, 4, 32'hF, dout, oe_bad);
    tck_pulse(1'b1, 1'b0, t, o);
    tck_pulse(1'b0, 1'b0, t, o);
    tck_pulse(1'b0, 1'b0, t, o);
    tck_pulse(1'b0, 1'b1, t, o);
    repeat (4) @(negedge clk);
    check("mid_shift_oe", 32'(jif.tdo_oe), 32'h1);
    check("mid_shift_ir", 32'(dbg_ir), 32'hF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", 32'(jif.tdo_oe), 32'h0);
    check("mid_rst_ir", 32'(dbg_ir), 32'h1);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_TLR));
    check("mid_rst_user_dr", 32'(user_dr), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    go_idle();
    scan(1'b0, 32, 32'h0, dout, oe_bad);
    check("post_rst_idcode", dout, 32'h020F10DD);
    check("post_rst_oe", 32'(oe_bad), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
